hd_timing_gen: RTL

HD_TIMING_GEN -- requirements
Module: hd_timing_gen

---
 rtl/hd_timing_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/hd_timing_gen.sv
// Beat timing generator: sequences one-hot W beats (B1/B2/B3) on the falling edge of T3,
// starting on a QD rising edge and halting on STOP, STEP_MODE or an accumulated stop request.
module hd_timing_gen (
    input  logic        T3,
    input  logic        CLR,
    input  logic        QD,
    input  logic        STEP_MODE,
    input  logic        SHORT,
    input  logic        LONG,
    input  logic        STOP,
    output logic [3:1]  W,
    output logic        RUN,
    output logic        HALTED,
    output logic        CYC_END,
    output logic [15:0] CYCLES
);

    typedef enum logic [2:0] {
        IDLE,
        B1,
        B2,
        B3,
        HALT
    } state_e;

    state_e      state_q, state_d;
    logic [3:1]  w_q, w_d;
    logic        halted_q, halted_d;
    logic [15:0] cycles_q, cycles_d;
    logic        stop_pend_q, stop_pend_d;
    logic        qd_q;
    logic        armed_q;
    logic        qd_rise;
    logic        in_beat;
    logic        terminal;

    // armed_q stays low for the first edge after reset so a QD already high at release
    // is absorbed into qd_q instead of being seen as a start edge.
    assign qd_rise = QD & ~qd_q & armed_q;
    assign in_beat = (state_q == B1) || (state_q == B2) || (state_q == B3);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        cycles_d    = cycles_q;
        terminal    = 1'b0;

        unique case (state_q)
            IDLE, HALT: if (qd_rise) state_d = B1;
            B1: begin
                terminal = SHORT;
                if (!SHORT) state_d = B2;
            end
            B2: begin
                terminal = ~LONG;
                if (LONG) state_d = B3;
            end
            B3:      terminal = 1'b1;
            default: state_d = IDLE;
        endcase

        if (in_beat && STOP) stop_pend_d = 1'b1;

        if (terminal) begin
            cycles_d = cycles_q + 16'd1;
            state_d  = (stop_pend_q | STOP | STEP_MODE) ? HALT : B1;
        end

        // Every entry to B1 starts a fresh machine cycle with no stale stop request.
        if (state_d == B1) stop_pend_d = 1'b0;
    end

    always_comb begin
        w_d = 3'b000;
        unique case (state_d)
            B1:      w_d = 3'b001;
            B2:      w_d = 3'b010;
            B3:      w_d = 3'b100;
            default: w_d = 3'b000;
        endcase
        halted_d = (state_d == HALT);
    end

    always_ff @(negedge T3 or negedge CLR) begin
        if (!CLR) begin
            state_q     <= IDLE;
            w_q         <= 3'b000;
            halted_q    <= 1'b0;
            cycles_q    <= 16'd0;
            stop_pend_q <= 1'b0;
            qd_q        <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            w_q         <= w_d;
            halted_q    <= halted_d;
            cycles_q    <= cycles_d;
            stop_pend_q <= stop_pend_d;
            qd_q        <= QD;
            armed_q     <= 1'b1;
        end
    end

    assign W       = w_q;
    assign RUN     = |w_q;
    assign HALTED  = halted_q;
    assign CYC_END = terminal;
    assign CYCLES  = cycles_q;

endmodule
